// File: rtl/muldiv_unit_pkg.sv
// Shared multiply/divide constants: op encodings and FSM state encodings,
// so the decoder, hazard unit and muldiv_unit agree on every value.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } md_state_e;

   // Codes 000..011 are the iterative ops; bit 2 set means a move or no-op.
   function automatic logic md_is_muldiv(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
// Accumulator holds {upper W+1 bits, lower W bits}; purely combinational.
module muldiv_iter
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               i_div,
   input  logic [2*WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   output logic [2*WIDTH:0]   o_acc
);

   logic [WIDTH:0]   w_sum;
   logic [2*WIDTH:0] w_sh;
   logic [WIDTH+1:0] w_diff;

   always_comb begin
      w_sum  = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_opnd} : '0);
      w_sh   = {i_acc[2*WIDTH-1:0], 1'b0};
      // Borrow out of the trial subtract means the divisor did not fit.
      w_diff = {1'b0, w_sh[2*WIDTH:WIDTH]} - {2'b00, i_opnd};
      if (i_div) begin
         o_acc = w_sh;
         if (!w_diff[WIDTH+1]) begin
            o_acc[2*WIDTH:WIDTH] = w_diff[WIDTH:0];
            o_acc[0]             = 1'b1;
         end
      end else begin
         o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: magnitudes are iterated
// WIDTH cycles, then sign-corrected and committed in a single FIX cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int AW    = 2*WIDTH + 1;

   md_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [AW-1:0]      r_acc, w_acc_nxt;
   logic [WIDTH-1:0]   r_opnd, r_a_orig, r_hi, r_lo;
   logic               r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
   logic               w_accept, w_is_md, w_sgn, w_busy;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_fix_hi, w_fix_lo;
   logic [2*WIDTH-1:0] w_prod;

   assign w_accept = i_start && (r_state == ST_IDLE);
   assign w_is_md  = md_is_muldiv(i_op);
   assign w_sgn    = ~i_op[0];
   assign w_a_mag  = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_b_mag  = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .i_div  (r_is_div),
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_acc_nxt)
   );

   // Sign post-correction; a zero divisor bypasses the datapath result.
   always_comb begin
      w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
      w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      if (!r_is_div) begin
         w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod[WIDTH-1:0];
      end else if (r_div0) begin
         w_fix_hi = r_a_orig;
         w_fix_lo = '1;
      end else begin
         w_fix_hi = w_rem;
         w_fix_lo = w_quo;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_md) w_state_nxt = ST_CALC;
         ST_CALC: begin
            w_busy = 1'b1;
            if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
         end
         ST_FIX: begin
            w_busy      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_a_orig <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_md) begin
                     // Divide iterates on the dividend; multiply on the multiplier.
                     r_cnt    <= CNT_W'(WIDTH);
                     r_is_div <= i_op[1];
                     r_acc    <= {{(WIDTH+1){1'b0}}, i_op[1] ? w_a_mag : w_b_mag};
                     r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
                     r_neg_q  <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                     r_neg_r  <= w_sgn && i_a[WIDTH-1];
                     r_div0   <= (i_b == '0);
                     r_a_orig <= i_a;
                  end else if (i_op == MD_MTHI) begin
                     r_hi <= i_a;
                  end else if (i_op == MD_MTLO) begin
                     r_lo <= i_a;
                  end
               end
            end
            ST_CALC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            ST_FIX: begin
               r_hi   <= w_fix_hi;
               r_lo   <= w_fix_lo;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_busy = w_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS CPU, parametrised in operand width. It sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises `busy` so the hazard unit stalls any MFHI/MFLO or new mult/div until results are committed. Radix-2 shift-add and restoring-division datapath with sign pre/post-correction; one iteration per cycle.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; product is 2·`WIDTH`.
- `CNT_W`, $clog2(`WIDTH`+1), iteration counter width (derived, not overridden).

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; sampled on rising edge only when `busy`=0.
- `op`  in  3  operation: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 110/111 = no-op.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  mult/div in flight; hazard unit stalls on it.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Signedness: `op[0]`=0 signed, 1 unsigned (matches funct[0] convention). MTHI/MTLO ignore it.
- States: IDLE, CALC, FIX.
- IDLE: `start` with MULT/MULTU/DIV/DIVU → latch magnitudes (signed ops take |a|, |b|; unsigned pass through), record result signs, counter=`WIDTH`, go CALC. `start` with MTHI → hi←a; MTLO → lo←a; stay IDLE. `start` with 110/111 → no effect.
- CALC: one iteration per cycle, counter decrements; at counter=1 go FIX.
  - Multiply: shift-add over 2·`WIDTH` accumulator.
  - Divide: restoring, one quotient bit per cycle, `WIDTH`+1-bit partial remainder.
- FIX: apply sign correction, write hi/lo, pulse `done`, go IDLE.
  - Multiply: negate full 2·`WIDTH` product if signs differ; hi=upper half, lo=lower half.
  - Divide: lo=quotient, negated if operand signs differ; hi=remainder, sign of dividend.
- Divide by zero (b=0, any signedness): lo={`WIDTH`{1}}, hi=a (original, uncorrected); still takes full latency.
- Signed overflow (most-negative / −1): lo=most-negative, hi=0 (natural wrap); no flag.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO; the hazard unit must hold the instruction.
- hi/lo are not modified during CALC; they hold their previous values until FIX.

## Timing
- Reset (async, immediate): state=IDLE, `busy`=0, `done`=0, hi=0, lo=0, counter=0. Reset asserted mid-operation aborts; no partial result is written.
- Mult/div accepted at edge E0: `busy`=1 from E0 through E(`WIDTH`+1). At E(`WIDTH`+1), FIX commits hi/lo, `busy`→0, `done`→1 for one cycle. Total `WIDTH`+1 cycles (33 at default).
- A new `start` is accepted on the same edge that `done` is high (`busy`=0 then).
- MTHI/MTLO: hi/lo updated at the accepting edge; `busy` and `done` stay 0.
- `done` is registered; hi/lo are registered; `busy` is decoded from registered state (IDLE → 0).

## Structure
- Shared CPU package/header holds the MD_* op encodings and the IDLE/CALC/FIX state encodings, so the decoder and hazard unit use identical constants.
- One sub-module: `muldiv_iter`, the per-cycle shift-add / restore-subtract datapath step. It is combinational and selected by a mode bit. Sign handling, counter, FSM and HI/LO stay in `muldiv_unit`.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; `done` high exactly one cycle; `busy` high 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x1234 while idle → hi=0x1234 next cycle, `busy`=0, `done`=0. During a running DIV, `start` with MULT or MTLO 0xAAAA → ignored; the DIV result is correct and lo≠0xAAAA.
- `reset_n` low at cycle 10 of a DIV → `busy`, `done`, hi, lo all 0 immediately. After release, MULTU 3×4 → lo=12, hi=0 after 33 cycles.
